softmax_normalizer: RTL
=======================

# softmax_normalizer

Final stage of the DFX softmax datapath, directly downstream of the SFU. It buffers each N-lane exponent vector arriving on the SFU bypass path and pairs it with the FP16 reciprocal of that vector's sum from the SFU's AXI-Stream output. It then multiplies every lane by the reciprocal and emits the normalized N-lane softmax vector on an AXI-Stream master. The bypass path has no backpressure, so a small vector FIFO absorbs the skew between bypass arrival and reciprocal arrival.

## Interface
- N, 64: lanes per vector; lane i occupies bits [16i+15:16i] of every vector bus.
- DEPTH, 4: vector FIFO depth, power of two, ≥2.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_bypass_tvalid  in  1  bypass vector valid; no ready, push is unconditional.
- s_bypass_tdata  in  N*16  bypass vector, FP16 per lane.
- s_recip_tvalid  in  1  reciprocal valid.
- s_recip_tready  out  1  reciprocal accepted.
- s_recip_tdata  in  16  FP16 reciprocal.
- m_tvalid  out  1  output vector valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  N*16  normalized vector, FP16 per lane.
- bypass_ovf  out  1  sticky flag: a bypass vector was dropped.

## Operation
- **Vector FIFO** (DEPTH × N*16), in-order.
  - Push when s_bypass_tvalid.
  - Pop on a recip handshake.
  - Push while full with no same-cycle pop: the vector is dropped and bypass_ovf is set. bypass_ovf stays at 1 until rst.
  - Push while full with a same-cycle pop: the push is accepted and count is unchanged.
  - Read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- **Ready rule.** s_recip_tready = (count≠0) && (!m_tvalid || m_tready).
  - count is the registered count, so there is no fall-through: a vector pushed at edge t cannot pair before edge t+1.
- **Handshake** (s_recip_tvalid && s_recip_tready at an edge):
  - pop the FIFO head;
  - m_tdata[lane i] <= fpmul(head[lane i], s_recip_tdata);
  - m_tvalid <= 1.
- **Output register.** If m_tvalid && m_tready with no new handshake, m_tvalid <= 0. While m_tvalid && !m_tready, m_tdata is held stable.
- **Output FSM**, two states:
  - EMPTY (m_tvalid=0) → FULL on a handshake.
  - FULL → EMPTY on m_tready with no new handshake.
  - FULL → FULL on m_tready with a handshake (back-to-back).
- **fpmul, FP16 × FP16 → FP16:**
  - Sign = XOR of input signs.
  - Subnormal inputs (exp=0) are treated as signed zero.
  - Finite path: 11×11 mantissa product with hidden bits; normalize by 1 bit; exponent ea+eb−15 (+1 if normalized); round to nearest even.
  - Biased result exponent ≤0 after rounding → signed zero (no subnormal output).
  - Biased result exponent ≥31 → signed inf (exp=31, mant=0).
  - Either input NaN, or inf×zero → 16'h7E00.
  - inf × nonzero finite → signed inf.
  - zero × finite → signed zero.
- **Throughput and latency.**
  - One vector per cycle when the reciprocal stream and m_tready are continuously asserted.
  - The product is computed combinationally from the FIFO head and registered once.

## Timing
- **Reset values** (applied immediately while rst=1, independent of clk): m_tvalid=0, m_tdata=0, s_recip_tready=0, bypass_ovf=0. FIFO count and pointers are 0.
- **Reset mid-operation:** all queued vectors and the pending output are discarded. After rst deasserts, s_recip_tready stays 0 until a new bypass push.
- **Latency:**
  - bypass push at edge t → s_recip_tready can be 1 after edge t.
  - handshake at edge t+1 → m_tvalid=1 after edge t+1.
- s_recip_tready is combinational from registered state and m_tready only; it never depends on s_recip_tvalid.
- Vectors emerge in bypass arrival order, each paired with the k-th accepted reciprocal.

## Test plan
- **Basic pairing.** N=4. Push lanes {3C00,4000,3800,C200}, then recip 3400 → one cycle after the handshake, m_tvalid=1 with lanes {3400,3800,3000,BA00}.
- **Backpressure.** Queue 2 vectors; hold m_tready=0 for 5 cycles with recip valid → s_recip_tready=0 after the first handshake, m_tdata stable. Raising m_tready → both vectors delivered in order on consecutive cycles.
- **Overflow.** DEPTH=4, push 5 vectors with no recip → bypass_ovf=1 after the 5th push. Supplying 5 reciprocals → only the first 4 vectors emerge, and s_recip_tready=0 for the 5th.
- **Full with simultaneous push and pop.** FIFO full; push and handshake on the same edge → bypass_ovf stays 0, count stays 4, order preserved.
- **Special values.** Lanes {7BFF,0400,7C00,0001} × recip 4000 → {7C00,0800,7C00,0000}. Lanes {0400,7C00,7E00,8000} × recip 0400 → {0000,7C00,7E00,8000}. Recip 0000 with lane 7C00 → 7E00.
- **Async reset.** Assert rst between edges with 2 vectors queued and m_tvalid=1 → m_tvalid, s_recip_tready and bypass_ovf read 0 before the next edge. After release, recip valid with no push → no output.

Source files
------------

// File: rtl/softmax_normalizer.sv
// softmax_normalizer: pairs buffered exponent vectors with their FP16 reciprocal
// and emits the lane-wise FP16 product on an AXI-Stream master.
module softmax_normalizer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_bypass_tvalid,
  input  logic [N*16-1:0] s_bypass_tdata,
  input  logic            s_recip_tvalid,
  output logic            s_recip_tready,
  input  logic [15:0]     s_recip_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [N*16-1:0] m_tdata,
  output logic            bypass_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          r_state, w_next;
  logic [N*16-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;
  logic [N*16-1:0] r_data, w_prod;
  logic            r_ovf, w_full, w_hs, w_push;
  // Subnormals flush to zero on input; results below the normal range flush to zero.
  function automatic logic [15:0] fpmul(input logic [15:0] a, input logic [15:0] b);
    logic        s, an, bn, ai, bi, az, bz, g, st, inc;
    logic [21:0] p;
    logic [9:0]  m, mo;
    logic [11:0] r;
    logic [7:0]  e;
    s   = a[15] ^ b[15];
    an  = (&a[14:10]) && (|a[9:0]);
    bn  = (&b[14:10]) && (|b[9:0]);
    ai  = (&a[14:10]) && !(|a[9:0]);
    bi  = (&b[14:10]) && !(|b[9:0]);
    az  = a[14:10] == 5'd0;
    bz  = b[14:10] == 5'd0;
    p   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    m   = p[21] ? p[20:11] : p[19:10];
    g   = p[21] ? p[10] : p[9];
    st  = p[21] ? |p[9:0] : |p[8:0];
    inc = g && (st || m[0]);
    r   = {2'b01, m} + 12'(inc);
    mo  = r[11] ? 10'd0 : r[9:0];
    e   = 8'(a[14:10]) + 8'(b[14:10]) + 8'(p[21]) + 8'(r[11]) - 8'd15;
    return (an || bn || (ai && bz) || (az && bi)) ? 16'h7E00 :
           (ai || bi)                             ? {s, 15'h7C00} :
           (az || bz || e[7] || e == 8'd0)        ? {s, 15'h0000} :
           (e >= 8'd31)                           ? {s, 15'h7C00} :
                                                    {s, e[4:0], mo};
  endfunction
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign w_prod[16*i +: 16] = fpmul(r_mem[r_rd][16*i +: 16], s_recip_tdata);
  end
  assign w_full         = r_count == CW'(DEPTH);
  assign s_recip_tready = (r_count != '0) && (r_state == EMPTY || m_tready);
  assign w_hs           = s_recip_tvalid && s_recip_tready;
  assign w_push         = s_bypass_tvalid && (!w_full || w_hs);
  assign m_tvalid       = r_state == FULL;
  assign m_tdata        = r_data;
  assign bypass_ovf     = r_ovf;
  always_comb w_next = w_hs ? FULL : (m_tready ? EMPTY : r_state);
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= s_bypass_tdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_data  <= w_hs ? w_prod : r_data;
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_hs);
      r_count <= r_count + CW'(w_push) - CW'(w_hs);
      r_ovf   <= r_ovf || (s_bypass_tvalid && !w_push);
    end
  end
endmodule
